sram_word_ctrl: RTL and testbench
=================================

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

Interface
REQ-001 The block SHALL have one parameter, SRAM_WAIT (default 2): extra wait cycles per halfword SRAM access, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port wr_en, input, 1 bit: write request from the requester.
REQ-005 The block SHALL have port rd_en, input, 1 bit: read request from the requester.
REQ-006 The block SHALL have port address, input, 32 bits: byte address; only address[18:2] is used.
REQ-007 The block SHALL have port writeData, input, 32 bits: the write word.
REQ-008 The block SHALL have port readData, output, 32 bits: the last completed read word (registered).
REQ-009 The block SHALL have port ready, output, 1 bit: low while a request is pending or executing.
REQ-010 The block SHALL have port SRAM_DQ, inout, 16 bits: the SRAM data bus.
REQ-011 The block SHALL have port SRAM_ADDR, output, 18 bits: the SRAM halfword address.
REQ-012 The block SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N and SRAM_WE_N, each output, 1 bit, active-low SRAM controls.

Function
REQ-013 The FSM SHALL have states IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-014 In IDLE, a request sampled at a rising edge SHALL latch address, writeData and the operation and move to WR_LO if wr_en=1, else to RD_LO if rd_en=1; wr_en SHALL win when both are high.
REQ-015 Each LO/HI phase SHALL last exactly SRAM_WAIT+1 cycles, timed by a wait counter that is cleared on phase entry.
REQ-016 RD_LO SHALL go to RD_HI, WR_LO to WR_HI, and RD_HI/WR_HI to DONE; DONE SHALL last one cycle and then go to IDLE.
REQ-017 The SRAM halfword address SHALL be {address[18:2],1'b0} in LO phases and {address[18:2],1'b1} in HI phases, taken from the latched address.
REQ-018 Input changes after acceptance SHALL be ignored until DONE.
REQ-019 ready SHALL be computed combinationally as (IDLE and not(rd_en or wr_en)) or DONE, so it drops in the same cycle a request appears.
REQ-020 The requester SHALL drop or change its request on the edge at which it samples ready=1; a request still held in DONE SHALL start a new transaction from IDLE.
REQ-021 Reads SHALL capture SRAM_DQ in the last cycle of RD_LO into readData[15:0] and in the last cycle of RD_HI into readData[31:16]; readData SHALL be valid while ready=1 in DONE and SHALL hold until the next read captures.
REQ-022 Writes SHALL drive SRAM_DQ with writeData[15:0] in WR_LO and writeData[31:16] in WR_HI, and SHALL hold SRAM_DQ at high-Z in all other states.
REQ-023 SRAM_WE_N SHALL be 0 for the first SRAM_WAIT cycles of each write phase and 1 in its last cycle and in every other state.
REQ-024 SRAM_OE_N SHALL be 0 in RD_LO/RD_HI and 1 otherwise.
REQ-025 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be held at constant 0.
REQ-026 Read latency from the acceptance edge to ready=1 SHALL be 2*(SRAM_WAIT+1)+1 cycles; write latency SHALL be identical.

Reset
REQ-027 When rst=0 at an edge, the block SHALL force state IDLE, counter 0, readData 0, latched registers 0, SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ high-Z, including mid-transaction.
REQ-028 A mid-transaction reset SHALL commit no further SRAM writes and SHALL clear any partial read.
REQ-029 During reset, ready SHALL follow REQ-019 with state IDLE.

Structure
REQ-030 A shared package sram_pkg SHALL hold the state enum, the SRAM_WAIT default and the widths (ADDR 18, DQ 16, WORD 32).
REQ-031 One sub-module, sram_wait_counter (clear/enable in, terminal-count out), SHALL time the phases; the FSM and datapath SHALL stay in sram_word_ctrl.

Verification
REQ-032 Write then read: write 0xDEADBEEF to address 0x0000_0404, then read it back -> SRAM_ADDR 0x202 then 0x203 with DQ 0xBEEF then 0xDEAD; the read returns readData=0xDEADBEEF; with SRAM_WAIT=2, ready=1 exactly 7 cycles after each acceptance.
REQ-033 Simultaneous request: rd_en=wr_en=1 -> a write is performed (WE_N pulses, OE_N stays 1).
REQ-034 Held request: rd_en held high through DONE -> a second read starts, and ready is 1 for one cycle only.
REQ-035 Mid-operation reset: rst=0 in WR_HI -> next cycle IDLE, WE_N=1, DQ=Z, readData=0; a subsequent read of the high half returns old contents.
REQ-036 Input change: address changed to 0x8 during RD_LO -> SRAM_ADDR stays at the latched halfwords.
REQ-037 Parameter sweep: SRAM_WAIT=1 and SRAM_WAIT=15 -> latencies of 5 and 33 cycles respectively.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and widths for the halfword SRAM word controller.
package sram_pkg;

  localparam int unsigned SRAM_WAIT_DEF = 2;
  localparam int unsigned ADDR_W        = 18;
  localparam int unsigned DQ_W          = 16;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WADDR_W       = ADDR_W - 1;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts 0..TERM inside one SRAM phase, flags the last cycle.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int unsigned TERM = SRAM_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc      = (cnt_q == CNT_W'(TERM));
  assign cnt_nxt = cnt_d;

  // Saturates at TERM so an idle-but-enabled counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// 32-bit word access over a 16-bit asynchronous SRAM, split into LO/HI
// halfword phases; control, address and data-bus outputs are registered.
module sram_word_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData,
  output logic              ready,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  state_e              state_q, state_d;
  logic [WADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DQ_W-1:0]     dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;

  logic                req;
  logic                cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                nxt_hi, nxt_wr, nxt_rd;
  logic                unused_addr;

  assign req         = rd_en | wr_en;
  assign unused_addr = ^{address[WORD_W-1:ADDR_W+1], address[1:0]};

  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q != IDLE) && (state_q != DONE);

  sram_wait_counter #(
    .TERM (SRAM_WAIT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt_nxt (cnt_nxt),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write wins over read when both are requested together.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WR_LO;
        end else if (rd_en) begin
          state_d = RD_LO;
        end
      end
      RD_LO:   if (cnt_tc) state_d = RD_HI;
      RD_HI:   if (cnt_tc) state_d = DONE;
      WR_LO:   if (cnt_tc) state_d = WR_HI;
      WR_HI:   if (cnt_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so the SRAM pins come
  // straight from flops.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if ((state_q == IDLE) && req) begin
      addr_d  = address[ADDR_W:2];
      wdata_d = writeData;
    end
    if ((state_q == RD_LO) && cnt_tc) begin
      rdata_d[DQ_W-1:0] = SRAM_DQ;
    end
    if ((state_q == RD_HI) && cnt_tc) begin
      rdata_d[WORD_W-1:DQ_W] = SRAM_DQ;
    end

    nxt_hi = (state_d == RD_HI) || (state_d == WR_HI);
    nxt_wr = (state_d == WR_LO) || (state_d == WR_HI);
    nxt_rd = (state_d == RD_LO) || (state_d == RD_HI);

    sram_addr_d = {addr_d, nxt_hi};
    we_n_d      = !(nxt_wr && (cnt_nxt < CNT_W'(SRAM_WAIT)));
    oe_n_d      = !nxt_rd;
    dq_oe_d     = nxt_wr;
    dq_out_d    = nxt_hi ? wdata_d[WORD_W-1:DQ_W] : wdata_d[DQ_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign readData  = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: halfword SRAM model plus a word-level reference memory.
module tb_sram_word_ctrl;

  localparam int W_MAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;

  logic        wr1 = 1'b0, rd1 = 1'b0, wr15 = 1'b0, rd15 = 1'b0;
  logic [31:0] rdata1, rdata15;
  logic        ready1, ready15;
  wire  [15:0] dq1, dq15;
  logic [17:0] addr1, addr15;
  logic        ub1, lb1, ce1, oe1, we1, ub15, lb15, ce15, oe15, we15;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [0:262143];
  logic        wr_pend = 1'b0;
  logic [17:0] pend_a;
  logic [15:0] pend_d;
  logic [31:0] ref_word [int unsigned];

  always #5 clk = ~clk;

  sram_word_ctrl #(.SRAM_WAIT(W_MAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n));

  sram_word_ctrl #(.SRAM_WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(address),
    .writeData(writeData), .readData(rdata1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(addr1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1),
    .SRAM_OE_N(oe1), .SRAM_WE_N(we1));

  sram_word_ctrl #(.SRAM_WAIT(15)) dut_w15 (
    .clk(clk), .rst(rst), .wr_en(wr15), .rd_en(rd15), .address(address),
    .writeData(writeData), .readData(rdata15), .ready(ready15), .SRAM_DQ(dq15),
    .SRAM_ADDR(addr15), .SRAM_UB_N(ub15), .SRAM_LB_N(lb15), .SRAM_CE_N(ce15),
    .SRAM_OE_N(oe15), .SRAM_WE_N(we15));

  // SRAM drives the bus while output-enabled; the sweep instances see a fixed pattern.
  assign sram_dq = oe_n ? 16'hzzzz : sram[sram_addr];
  assign dq1     = oe1  ? 16'hzzzz : 16'h1234;
  assign dq15    = oe15 ? 16'hzzzz : 16'h1234;

  // A write pulse commits when WE_N returns high; a reset aborts it.
  always @(posedge clk) begin
    if (!rst) begin
      wr_pend <= 1'b0;
    end else if (we_n === 1'b0) begin
      wr_pend <= 1'b1;
      pend_a  <= sram_addr;
      pend_d  <= sram_dq;
    end else if (wr_pend) begin
      sram[pend_a] <= pend_d;
      wr_pend      <= 1'b0;
    end
  end

  function automatic logic [15:0] init_hw(input int unsigned i);
    return 16'((i * 32'd40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [31:0] ref_get(input logic [16:0] wa);
    int unsigned k;
    k = 32'(wa);
    if (ref_word.exists(k)) return ref_word[k];
    return {init_hw(2 * k + 1), init_hw(2 * k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance, watching every pin cycle by cycle.
  task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] alt_a, input string nm);
    int          lat, k, addr_err, we_err, oe_err, dq_err;
    logic        hi;
    logic [16:0] wa;
    logic [31:0] exp_rd;
    wa = a[18:2];
    exp_rd = ref_get(wa);
    lat = 0; addr_err = 0; we_err = 0; oe_err = 0; dq_err = 0;
    address = a; writeData = d; wr_en = w; rd_en = r;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_drop: got %b want 0", nm, ready);
    end
    while (1) begin
      tick();
      lat++;
      if (lat == 1) begin
        address = alt_a; writeData = ~d;
      end
      if (ready === 1'b1 || lat >= 200) break;
      k  = (lat - 1) % (W_MAIN + 1);
      hi = (lat > W_MAIN + 1);
      if (sram_addr !== {wa, hi}) addr_err++;
      if (we_n !== ((w && k < W_MAIN) ? 1'b0 : 1'b1)) we_err++;
      if (oe_n !== (w ? 1'b1 : 1'b0)) oe_err++;
      if (w && sram_dq !== (hi ? d[31:16] : d[15:0])) dq_err++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (lat != 2 * W_MAIN + 3) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, 2 * W_MAIN + 3);
    end
    checks++;
    if (addr_err != 0 || we_err != 0 || oe_err != 0 || dq_err != 0) begin
      errors++;
      $display("FAIL %s pins: addr_err=%0d we_err=%0d oe_err=%0d dq_err=%0d want all 0",
               nm, addr_err, we_err, oe_err, dq_err);
    end
    if (w) begin
      ref_word[32'(wa)] = d;
    end else begin
      checks++;
      if (readData !== exp_rd) begin
        errors++; $display("FAIL %s readData: got %h want %h", nm, readData, exp_rd);
      end
    end
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", nm, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b1 || readData !== 32'h0 || we_n !== 1'b1 || oe_n !== 1'b1 ||
        sram_addr !== 18'h0 || {ce_n, ub_n, lb_n} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: ready=%b rd=%h we_n=%b oe_n=%b addr=%h ce/ub/lb=%b want 1 0 1 1 0 000",
               ready, readData, we_n, oe_n, sram_addr, {ce_n, ub_n, lb_n});
    end
    rd_en = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_req: got %b want 0", ready);
    end
    rd_en = 1'b0;
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    run_op(1'b1, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0000_0404, "wr_deadbeef");
    checks++;
    if (sram[18'h202] !== 16'hBEEF || sram[18'h203] !== 16'hDEAD) begin
      errors++;
      $display("FAIL wr_deadbeef_mem: got %h/%h want beef/dead", sram[18'h202], sram[18'h203]);
    end
    run_op(1'b0, 1'b1, 32'h0000_0404, 32'h0, 32'h0000_0404, "rd_deadbeef");
  endtask

  task automatic test_simultaneous();
    run_op(1'b1, 1'b1, 32'h0000_0120, 32'h0BAD_F00D, 32'h0000_0120, "both_req");
    checks++;
    if (sram[18'h090] !== 16'hF00D || sram[18'h091] !== 16'h0BAD) begin
      errors++;
      $display("FAIL both_req_mem: got %h/%h want f00d/0bad", sram[18'h090], sram[18'h091]);
    end
  endtask

  task automatic test_held_request();
    int n;
    logic [31:0] exp_rd;
    exp_rd = ref_get(17'h101);
    address = 32'h0000_0404; rd_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 50);
    checks++;
    if (n != 2 * W_MAIN + 3) begin
      errors++; $display("FAIL held_first_latency: got %0d want %0d", n, 2 * W_MAIN + 3);
    end
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL held_ready_pulse: got %b want 0", ready);
    end
    tick();
    checks++;
    if (oe_n !== 1'b0 || sram_addr !== 18'h202) begin
      errors++; $display("FAIL held_restart: oe_n=%b addr=%h want 0 202", oe_n, sram_addr);
    end
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 50);
    rd_en = 1'b0;
    checks++;
    if (n >= 50 || readData !== exp_rd) begin
      errors++; $display("FAIL held_second_read: n=%0d got %h want %h", n, readData, exp_rd);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int n;
    logic [31:0] old_w, new_w, a;
    a = 32'h0000_0840; old_w = 32'hCAFE_F00D; new_w = 32'h1357_2468;
    run_op(1'b1, 1'b0, a, old_w, a, "mr_wr_old");
    run_op(1'b0, 1'b1, a, 32'h0, a, "mr_rd_old");
    address = a; writeData = new_w; wr_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(sram_addr[0] === 1'b1 && we_n === 1'b0) && n < 50);
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL mr_reach_wr_hi: got timeout want WR_HI");
    end
    wr_en = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (we_n !== 1'b1 || oe_n !== 1'b1 || readData !== 32'h0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mr_after_reset: we_n=%b oe_n=%b rd=%h ready=%b want 1 1 0 1",
               we_n, oe_n, readData, ready);
    end
    rst = 1'b1;
    tick();
    ref_word[32'(a[18:2])] = {old_w[31:16], new_w[15:0]};
    run_op(1'b0, 1'b1, a, 32'h0, a, "mr_rd_after");
  endtask

  task automatic test_input_change();
    run_op(1'b0, 1'b1, 32'h0000_0404, 32'h0, 32'h0000_0008, "in_change");
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        w, r;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      a[18:2] = 17'(17'h100 + 17'($urandom_range(0, 7)));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(w, r, a, d, $urandom, "rand_op");
    end
  endtask

  task automatic sweep_op(input int which, input logic w);
    int lat;
    address = 32'h0000_0100; writeData = 32'hA5A5_5A5A;
    if (which == 1) begin wr1 = w; rd1 = !w; end
    else begin wr15 = w; rd15 = !w; end
    lat = 0;
    while (1) begin
      tick();
      lat++;
      if (((which == 1) ? ready1 : ready15) === 1'b1 || lat >= 200) break;
    end
    wr1 = 1'b0; rd1 = 1'b0; wr15 = 1'b0; rd15 = 1'b0;
    checks++;
    if (lat != 2 * which + 3) begin
      errors++; $display("FAIL sweep_w%0d_latency wr=%b: got %0d want %0d", which, w, lat, 2 * which + 3);
    end
    if (!w) begin
      checks++;
      if (((which == 1) ? rdata1 : rdata15) !== 32'h1234_1234) begin
        errors++;
        $display("FAIL sweep_w%0d_read: got %h want 12341234", which,
                 (which == 1) ? rdata1 : rdata15);
      end
    end
    tick();
  endtask

  task automatic test_sweep();
    sweep_op(1, 1'b1);
    sweep_op(1, 1'b0);
    sweep_op(15, 1'b1);
    sweep_op(15, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = init_hw(32'(i));
    test_reset();
    test_write_read();
    test_simultaneous();
    test_held_request();
    test_mid_reset();
    test_input_change();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
